// File: rtl/wb_trace_checker.sv
// wb_trace_checker: compares CPU write-back events against a reference trace ROM
// read through a 2-entry prefetch queue; latches pass/fail and drives LEDs.
module wb_trace_checker #(
    parameter int          TEST_COUNT = 20,
    parameter logic [31:0] FINISH_PC  = 32'h0000_0070,
    parameter int          ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       debug_wb_pc,
    input  logic              debug_wb_rf_wen,
    input  logic [4:0]        debug_wb_rf_addr,
    input  logic [31:0]       debug_wb_rf_wdata,
    output logic              trace_rd_en,
    output logic [ADDR_W-1:0] trace_addr,
    input  logic [71:0]       trace_rdata,
    output logic              test_pass,
    output logic              test_err,
    output logic [3:0]        err_code,
    output logic [15:0]       pass_count,
    output logic [15:0]       leds
);
    typedef enum logic [1:0] {RUN, PASS, FAIL} state_t;
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] LAST = PW'(TEST_COUNT);

    state_t      st_q, st_d;
    logic [68:0] q0_q, q0_d, q1_q, q1_d, hold_q, hold_d;
    logic [1:0]  occ_q, occ_d, occ_pop;
    logic        inflight_q, hold_v_q, hold_v_d;
    logic [PW-1:0] rd_ptr_q;
    logic [15:0] pass_count_q, pass_count_d;
    logic [3:0]  err_code_q, err_code_d;
    logic        run, ev, finish, head_v, cmp, pc_ok, addr_ok, data_ok, consume, pending;
    logic [68:0] cur, cand, rd_entry;
    logic        unused_rdata;

    // Entries are kept as {pc, addr, wdata}; ROM bits [39:37] carry nothing.
    assign unused_rdata = ^trace_rdata[39:37];
    assign rd_entry     = {trace_rdata[71:40], trace_rdata[36:0]};
    assign cur          = {debug_wb_pc, debug_wb_rf_addr, debug_wb_rf_wdata};
    assign run          = st_q == RUN;
    assign ev           = debug_wb_rf_wen && debug_wb_rf_addr != 5'd0;
    assign finish       = debug_wb_pc == FINISH_PC;
    assign head_v       = occ_q != 2'd0;
    assign cand         = hold_v_q ? hold_q : cur;
    assign cmp          = run && !finish && head_v && (hold_v_q || ev);
    assign pc_ok        = cand[68:37] == q0_q[68:37] + 32'd4;
    assign addr_ok      = cand[36:32] == q0_q[36:32];
    assign data_ok      = cand[31:0] == q0_q[31:0];
    assign consume      = cmp && pc_ok && addr_ok && data_ok;
    assign pending      = rd_ptr_q < LAST || inflight_q;
    assign trace_rd_en  = run && rd_ptr_q < LAST &&
                          {1'b0, occ_q} + {2'b0, inflight_q} < 3'd2 + {2'b0, consume};
    assign trace_addr   = rd_ptr_q[ADDR_W-1:0];

    // Pop the head first, then push returning ROM data behind whatever remains.
    assign occ_pop = occ_q - {1'b0, consume};
    assign occ_d   = occ_pop + {1'b0, inflight_q};
    assign q0_d    = inflight_q && occ_pop == 2'd0 ? rd_entry : consume ? q1_q : q0_q;
    assign q1_d    = inflight_q && occ_pop != 2'd0 ? rd_entry : q1_q;

    always_comb begin
        st_d         = st_q;
        hold_v_d     = hold_v_q;
        hold_d       = hold_q;
        pass_count_d = pass_count_q + {15'd0, consume};
        err_code_d   = err_code_q;
        if (run && finish) begin
            st_d     = PASS;
            hold_v_d = 1'b0;
        end else if (cmp && !consume) begin
            st_d       = FAIL;
            err_code_d = !pc_ok ? 4'd1 : !addr_ok ? 4'd2 : 4'd3;
        end else if (run && ev) begin
            if (hold_v_q && !head_v) begin
                st_d       = FAIL;
                err_code_d = 4'd5;
            end else if (hold_v_q || (!head_v && pending)) begin
                hold_v_d = 1'b1;
                hold_d   = cur;
            end else if (!head_v) begin
                st_d       = FAIL;
                err_code_d = 4'd4;
            end
        end else if (run && hold_v_q && head_v) begin
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q         <= RUN;
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            rd_ptr_q     <= '0;
            hold_v_q     <= 1'b0;
            pass_count_q <= 16'd0;
            err_code_q   <= 4'd0;
        end else begin
            st_q         <= st_d;
            occ_q        <= occ_d;
            inflight_q   <= trace_rd_en;
            rd_ptr_q     <= rd_ptr_q + {{ADDR_W{1'b0}}, trace_rd_en};
            hold_v_q     <= hold_v_d;
            pass_count_q <= pass_count_d;
            err_code_q   <= err_code_d;
        end
        q0_q   <= q0_d;
        q1_q   <= q1_d;
        hold_q <= hold_d;
    end

    assign test_pass  = st_q == PASS;
    assign test_err   = st_q == FAIL;
    assign err_code   = err_code_q;
    assign pass_count = pass_count_q;
    assign leds       = run ? 16'hFFFF : test_err ? {err_code_q, pass_count_q[11:0]} : 16'h0000;
endmodule

// File: tb/tb_wb_trace_checker.sv
// tb_wb_trace_checker: directed and randomized trace runs against a spec-level model
// of expected outcome (entry index, final state, failure code).
module tb_wb_trace_checker;
    localparam int TC = 20;
    localparam logic [31:0] FPC = 32'h0000_0070;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] debug_wb_pc;
    logic        debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_addr;
    logic [31:0] debug_wb_rf_wdata;
    logic        trace_rd_en;
    logic [4:0]  trace_addr;
    logic [71:0] trace_rdata = '0;
    logic        test_pass, test_err;
    logic [3:0]  err_code;
    logic [15:0] pass_count, leds;

    logic [71:0] rom [TC];
    int errors = 0;
    int checks = 0;
    int m_state, m_idx;
    logic [3:0] m_code;

    wb_trace_checker dut (
        .clk(clk), .reset(reset),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_addr(debug_wb_rf_addr), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .trace_rd_en(trace_rd_en), .trace_addr(trace_addr), .trace_rdata(trace_rdata),
        .test_pass(test_pass), .test_err(test_err), .err_code(err_code),
        .pass_count(pass_count), .leds(leds)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (trace_rd_en) trace_rdata <= rom[trace_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_leds();
        return m_state == 0 ? 16'hFFFF : m_state == 1 ? 16'h0000 : {m_code, 12'(m_idx)};
    endfunction

    task automatic chk_model(input string tag);
        chk({tag, ".pass"}, 32'(test_pass), 32'(m_state == 1));
        chk({tag, ".err"}, 32'(test_err), 32'(m_state == 2));
        chk({tag, ".code"}, 32'(err_code), 32'(m_code));
        chk({tag, ".count"}, 32'(pass_count), 32'(m_idx));
        chk({tag, ".leds"}, 32'(leds), 32'(m_leds()));
    endtask

    // Outcome model: each event is matched against the next trace entry in order.
    task automatic model(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d, input logic w);
        if (m_state != 0) return;
        if (pc == FPC) m_state = 1;
        else if (w && a != 5'd0) begin
            if (m_idx == TC) begin m_state = 2; m_code = 4'd4; end
            else if (pc != rom[m_idx][71:40] + 32'd4) begin m_state = 2; m_code = 4'd1; end
            else if (a != rom[m_idx][36:32]) begin m_state = 2; m_code = 4'd2; end
            else if (d != rom[m_idx][31:0]) begin m_state = 2; m_code = 4'd3; end
            else m_idx++;
        end
    endtask

    task automatic cyc(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d, input logic w);
        debug_wb_pc = pc;
        debug_wb_rf_addr = a;
        debug_wb_rf_wdata = d;
        debug_wb_rf_wen = w;
        model(pc, a, d, w);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(32'd0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic good(input int i);
        cyc(rom[i][71:40] + 32'd4, rom[i][36:32], rom[i][31:0], 1'b1);
    endtask

    function automatic logic [4:0] other_addr(input logic [4:0] a);
        return 5'((int'(a) % 31) + 1);
    endfunction

    task automatic do_reset(input string tag);
        logic [31:0] pc;
        debug_wb_pc = 32'd0;
        debug_wb_rf_addr = 5'd0;
        debug_wb_rf_wdata = 32'd0;
        debug_wb_rf_wen = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < TC; i++) begin
            pc = $urandom & 32'hFFFF_FFFC;
            while (pc == FPC - 32'd4) pc = $urandom & 32'hFFFF_FFFC;
            rom[i] = {pc, 3'($urandom), 5'($urandom_range(1, 31)), 32'($urandom)};
        end
        @(negedge clk);
        reset = 1'b0;
        m_state = 0;
        m_idx = 0;
        m_code = 4'd0;
        chk_model(tag);
        chk({tag, ".rd_en0"}, 32'(trace_rd_en), 32'd1);
        chk({tag, ".addr0"}, 32'(trace_addr), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        @(negedge clk);

        do_reset("rst");
        idle();
        chk("rd1.en", 32'(trace_rd_en), 32'd1);
        chk("rd1.addr", 32'(trace_addr), 32'd1);
        idle();
        for (int i = 0; i < TC; i++) good(i);
        chk("clean.count", 32'(pass_count), 32'd20);
        cyc(FPC, 5'd0, 32'd0, 1'b0);
        chk_model("clean");
        chk("clean.pass", 32'(test_pass), 32'd1);
        chk("clean.leds", 32'(leds), 32'h0000);
        chk("clean.rd_en", 32'(trace_rd_en), 32'd0);

        do_reset("rst_data");
        idle();
        idle();
        for (int i = 0; i < 3; i++) good(i);
        cyc(rom[3][71:40] + 32'd4, rom[3][36:32], rom[3][31:0] + 32'd1, 1'b1);
        chk_model("data");
        chk("data.code", 32'(err_code), 32'd3);
        chk("data.leds", 32'(leds), 32'h3003);
        for (int i = 0; i < 3; i++) begin
            chk("data.rd_en_low", 32'(trace_rd_en), 32'd0);
            idle();
        end

        do_reset("rst_pc");
        idle();
        idle();
        cyc(rom[0][71:40] + 32'd8, other_addr(rom[0][36:32]), rom[0][31:0], 1'b1);
        chk_model("pc_wins");
        chk("pc_wins.code", 32'(err_code), 32'd1);

        do_reset("rst_hold");
        good(0);
        idle();
        idle();
        chk("hold.count", 32'(pass_count), 32'd1);
        chk("hold.err", 32'(test_err), 32'd0);
        good(1);
        chk_model("hold_next");

        do_reset("rst_ovf");
        good(0);
        good(1);
        chk("ovf.err", 32'(test_err), 32'd1);
        chk("ovf.code", 32'(err_code), 32'd5);
        chk("ovf.count", 32'(pass_count), 32'd0);
        chk("ovf.leds", 32'(leds), 32'h5000);

        do_reset("rst_exh");
        idle();
        idle();
        for (int i = 0; i < TC; i++) good(i);
        cyc(32'h0000_1000, 5'd5, 32'($urandom), 1'b1);
        chk_model("exh");
        chk("exh.code", 32'(err_code), 32'd4);
        chk("exh.leds", 32'(leds), 32'h4014);

        do_reset("rst_ign");
        idle();
        idle();
        good(0);
        cyc(rom[1][71:40] + 32'd4, 5'd0, rom[1][31:0], 1'b1);
        cyc(rom[1][71:40] + 32'd4, rom[1][36:32], rom[1][31:0], 1'b0);
        chk("ign.count", 32'(pass_count), 32'd1);
        chk("ign.err", 32'(test_err), 32'd0);
        good(1);
        chk_model("ign_next");
        do_reset("rst_mid");

        for (int t = 0; t < 4; t++) begin
            logic [31:0] pc, d;
            logic [4:0] a;
            do_reset("rst_rand");
            idle();
            idle();
            for (int i = 0; i < TC; i++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) idle();
                pc = rom[i][71:40] + 32'd4;
                a = rom[i][36:32];
                d = rom[i][31:0];
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 2))
                        0: pc = pc ^ 32'd4;
                        1: a = other_addr(a);
                        default: d = d ^ (32'd1 << $urandom_range(0, 31));
                    endcase
                end
                cyc(pc, a, d, 1'b1);
                chk("rand.count", 32'(pass_count), 32'(m_idx));
            end
            cyc(FPC, 5'd0, 32'd0, 1'b0);
            chk_model("rand_end");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_trace_checker.md
# wb_trace_checker

Synthesizable write-back trace checker for the RV32 5-stage pipeline. It sits beside the CPU on the `debug_wb_*` port and replaces the behavioural compare loop in the simulation top. It sequences reads from a synchronous reference-trace ROM through a 2-entry prefetch queue and compares every architectural register write against the expected entry at one event per cycle. It latches pass or fail status and drives the board LEDs.

## Interface
- `TEST_COUNT`, 20: number of trace entries; entries are indexed 0..TEST_COUNT-1.
- `FINISH_PC`, 32'h00000070: write-back PC that ends the test.
- `ADDR_W`, 5: trace ROM address width; must satisfy 2^ADDR_W >= TEST_COUNT.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `debug_wb_pc` input 32: PC of the instruction being written back.
- `debug_wb_rf_wen` input 1: register-file write enable.
- `debug_wb_rf_addr` input 5: destination register.
- `debug_wb_rf_wdata` input 32: write data.
- `trace_rd_en` output 1: ROM read strobe.
- `trace_addr` output ADDR_W: ROM read address.
- `trace_rdata` input 72: ROM data, valid the cycle after `trace_rd_en`. Field layout: [71:40] ref_pc, [36:32] ref_addr, [31:0] ref_wdata. Bits [39:37] are ignored.
- `test_pass` output 1: sticky pass flag.
- `test_err` output 1: sticky fail flag.
- `err_code` output 4: failure cause.
- `pass_count` output 16: number of matched events.
- `leds` output 16: status display.

## Operation
- Event: `debug_wb_rf_wen && debug_wb_rf_addr != 0`.
- States:
  - RUN (reset state). Goes to PASS when `debug_wb_pc == FINISH_PC`, checked every cycle regardless of wen. Goes to FAIL on any error.
  - PASS and FAIL are terminal; only `reset` leaves them.
  - The finish check has priority over a compare in the same cycle. A held event is discarded on finish.
- Prefetch queue (2 entries) plus read pointer `rd_ptr` and in-flight flag:
  - In RUN, issue a read when `occ + inflight - consume < 2` and `rd_ptr < TEST_COUNT`. Here `consume` means the head is retired this cycle.
  - On issue, `trace_addr = rd_ptr` and `rd_ptr` increments.
  - Returned data is pushed at the end of the return cycle.
  - No reads are issued in PASS or FAIL.
- Compare of head entry H against the current event, or against the held event if one is held (held event first):
  - Match when `pc == H.ref_pc + 4`, `addr == H.ref_addr` and `wdata == H.ref_wdata`.
  - On match: pop H and increment `pass_count`.
  - Mismatch priority and codes: PC = 1, addr = 2, data = 3. Go to FAIL.
- Hold register (1 entry):
  - An event that arrives while the queue is empty and more entries are pending (`rd_ptr < TEST_COUNT` or inflight) is captured.
  - If a held event is compared in the same cycle a new event arrives, the new event replaces it in the hold.
  - A new event arriving while the hold is full and uncompared gives FAIL, code 5 (overflow).
- Exhausted: an event arriving with the queue empty, no read in flight and `rd_ptr == TEST_COUNT` gives FAIL, code 4.
- LEDs:
  - RUN: 16'hFFFF.
  - PASS: 16'h0000.
  - FAIL: `{err_code, pass_count[11:0]}`.

## Timing
- Reset values: state RUN, `test_pass` 0, `test_err` 0, `err_code` 0, `pass_count` 0, `leds` 16'hFFFF, queue empty, hold empty, `rd_ptr` 0.
- `trace_rd_en` and `trace_addr` are combinational from registered state and this cycle's consume decision.
- First cycle after reset: reads of 0 and 1 are issued in cycles 0 and 1. Entry 0 is comparable from cycle 2.
- Steady state: back-to-back events, one per cycle, are accepted indefinitely with no overflow once the queue is primed.
- `test_pass`, `test_err`, `err_code` and `leds` update on the clock edge ending the deciding cycle (latency 1).
- Reset asserted mid-run or in a terminal state: at the next edge all state returns to reset values. Any ROM data returning after reset is dropped.

## Test plan
- Clean run: 20 matching events back-to-back from cycle 2, then `debug_wb_pc` = 0x70 -> `test_pass` = 1, `pass_count` = 20, `leds` = 0x0000, no overflow.
- Data mismatch on event 3 (wdata off by 1) -> `test_err` = 1, `err_code` = 3, `pass_count` = 3, `leds` = 0x3003, and `trace_rd_en` stays low afterwards.
- PC and addr both wrong on event 0 -> `err_code` = 1, because the PC check wins.
- Event in cycle 0 right after reset -> held, compared in cycle 2 and matches. A second event in cycle 1 -> FAIL with `err_code` = 5.
- 21st event with `TEST_COUNT` = 20 and no finish PC -> `err_code` = 4, `leds` = 0x4014.
- Events with addr 0 or wen = 0 -> ignored, `pass_count` unchanged. Then reset mid-run -> all outputs return to reset values and the next read is addr 0.
